// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock, for the reaction-timer display.
// Optional build macro: BIN_TO_BCD_BLANK_EN replaces leading zero digits with the display blank code 4'hF.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [1:0]            o_dbg_state
);
    // Handshake: start is a request honoured only on an edge where busy=0; done is a
    // single-cycle pulse marking the cycle in which bcd/overflow take their new values.

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = 32'(10**DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_shreg;
    logic [BCD_W-1:0]   r_scratch;
    logic               r_ovf_pend;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_scratch_next;
    logic               w_carry;
    logic               w_ovf;
    logic               w_bin_ovf;
    logic [BCD_W-1:0]   w_result;
`ifdef BIN_TO_BCD_BLANK_EN
    logic               w_lead;
`endif

    always_comb begin
        w_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[4*d +: 4] >= 4'd5)
                w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
            else
                w_adj[4*d +: 4] = r_scratch[4*d +: 4];
        end
    end

    assign {w_carry, w_scratch_next} = {w_adj, r_shreg[BIN_W-1]};
    assign w_bin_ovf = 32'(bin) > MAX_VAL;
    // A carry out of the top digit can only happen for values past the range, so it folds into overflow.
    assign w_ovf = r_ovf_pend | w_carry;

    always_comb begin
        w_result = w_scratch_next;
`ifdef BIN_TO_BCD_BLANK_EN
        w_lead = 1'b1;
`endif
        if (w_ovf) begin
            w_result = {DIGITS{4'h9}};
        end else begin
`ifdef BIN_TO_BCD_BLANK_EN
            for (int d = DIGITS - 1; d >= 1; d--) begin
                if (w_lead && (w_scratch_next[4*d +: 4] == 4'h0))
                    w_result[4*d +: 4] = 4'hF;
                else
                    w_lead = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_scratch  <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg    <= bin;
                        r_scratch  <= '0;
                        r_cnt      <= CNT_W'(BIN_W);
                        r_ovf_pend <= w_bin_ovf;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt - CNT_W'(1);
                    // Final shift: publish the result computed from this shift's output.
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_result;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign bcd         = r_bcd;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, handshake corner cases and random values
// against an arithmetic decimal model; honours BIN_TO_BCD_BLANK_EN the same way as the design.
module tb_bin_to_bcd_seq;
    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int BW      = 4 * DIGITS;
    localparam int MAX_VAL = 10**DIGITS - 1;
`ifdef BIN_TO_BCD_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic [BW-1:0]    bcd;
    logic             overflow;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    logic [BW:0] exp_q[$];

    typedef struct {
        logic [BIN_W-1:0] v;
        logic [BW-1:0]    exp_bcd;
        logic             exp_ovf;
    } vec_t;
    vec_t vecs[12];

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bin         (bin),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // decimal reference: digit d is (v / 10^d) mod 10, saturated past the range,
    // and blank above digit 0 whenever v < 10^d
    function automatic logic [BW:0] model(input int v);
        logic [BW-1:0] r;
        if (v > MAX_VAL) return {1'b1, {DIGITS{4'h9}}};
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'((v / (10**d)) % 10);
            if (BLANK && d >= 1 && v < 10**d) r[4*d +: 4] = 4'hF;
        end
        return {1'b0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // waits for done, counting edges from the current point; bcd must not move before done
    task automatic wait_done(input string name, input int exp_lat);
        logic [BW-1:0] held;
        bit moved;
        int lat;
        held  = bcd;
        moved = 1'b0;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (bcd !== held) moved = 1'b1;
        end
        check({name, " latency"}, lat, exp_lat);
        check({name, " bcd held while busy"}, 32'(moved), 0);
    endtask

    task automatic compare_result(input string name);
        logic [BW:0] exp;
        exp = exp_q.pop_front();
        check({name, " bcd"}, bcd, exp[BW-1:0]);
        check({name, " overflow"}, overflow, exp[BW]);
    endtask

    // one complete conversion with a single-cycle start, then the return to idle
    task automatic convert(input string name, input logic [BIN_W-1:0] v);
        start = 1'b1;
        bin   = v;
        exp_q.push_back(model(int'(v)));
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        wait_done(name, BIN_W);
        compare_result(name);
        @(posedge clk); #1;
        check({name, " done pulse ends"}, done, 0);
        check({name, " idle after done"}, busy, 0);
    endtask

    initial begin
        int v;
        int n_done;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;

        vecs[0]  = '{14'd1234,  16'h1234,                  1'b0};
        vecs[1]  = '{14'd0,     BLANK ? 16'hFFF0 : 16'h0000, 1'b0};
        vecs[2]  = '{14'd16383, 16'h9999,                  1'b1};
        vecs[3]  = '{14'd9999,  16'h9999,                  1'b0};
        vecs[4]  = '{14'd10000, 16'h9999,                  1'b1};
        vecs[5]  = '{14'd7,     BLANK ? 16'hFFF7 : 16'h0007, 1'b0};
        vecs[6]  = '{14'd42,    BLANK ? 16'hFF42 : 16'h0042, 1'b0};
        vecs[7]  = '{14'd999,   BLANK ? 16'hF999 : 16'h0999, 1'b0};
        vecs[8]  = '{14'd100,   BLANK ? 16'hF100 : 16'h0100, 1'b0};
        vecs[9]  = '{14'd10,    BLANK ? 16'hFF10 : 16'h0010, 1'b0};
        vecs[10] = '{14'd5005,  16'h5005,                  1'b0};
        vecs[11] = '{14'd1000,  16'h1000,                  1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset overflow", overflow, 0);
        check("reset bcd", bcd, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            start = 1'b1;
            bin   = vecs[i].v;
            exp_q.push_back({vecs[i].exp_ovf, vecs[i].exp_bcd});
            @(posedge clk); #1;
            start = 1'b0;
            bin   = BIN_W'($urandom);
            wait_done($sformatf("vec%0d", i), BIN_W);
            compare_result($sformatf("vec%0d", i));
            @(posedge clk); #1;
            check($sformatf("vec%0d idle", i), busy, 0);
        end

        // start while busy is ignored; held start is taken on the first idle edge
        start = 1'b1;
        bin   = 14'd42;
        exp_q.push_back(model(42));
        @(posedge clk); #1;
        start = 1'b0;
        bin   = BIN_W'($urandom);
        repeat (2) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        bin   = 14'd999;
        wait_done("busy start", BIN_W - 2);
        compare_result("busy start");
        exp_q.push_back(model(999));
        @(posedge clk); #1;
        check("held start idle gap", busy, 0);
        @(posedge clk); #1;
        check("held start accepted", busy, 1);
        start = 1'b0;
        bin   = BIN_W'($urandom);
        wait_done("held start", BIN_W);
        compare_result("held start");
        @(posedge clk); #1;

        // reset mid-conversion aborts without a done pulse
        start = 1'b1;
        bin   = 14'd500;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort bcd", bcd, 16'h0000);
        check("abort overflow", overflow, 0);
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("abort no done", n_done, 0);
        convert("after abort", 14'd7);

        // random values across the range, weighted toward small numbers and overflow
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(MAX_VAL + 1, 2**BIN_W - 1);
                default: v = $urandom_range(0, MAX_VAL);
            endcase
            convert($sformatf("rand%0d v=%0d", i, v), BIN_W'(v));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
